// File: rtl/byte_word_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_packer_pkg
//  Description : Shared state encoding, default widths and byte-pairing helper
//                for the byte-to-word packer.
//  Revision    : 1.0  initial release
// ============================================================================
package byte_word_packer_pkg;

    localparam int c_default_timeout_w = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    // Orders the held (first) byte and the incoming (second) byte into a word.
    function automatic logic [15:0] pair_bytes(
        input logic       msb_first,
        input logic [7:0] first_byte,
        input logic [7:0] second_byte
    );
        if (msb_first) begin
            pair_bytes = {first_byte, second_byte};
        end else begin
            pair_bytes = {second_byte, first_byte};
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_word_packer_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_counter
//  Description : Generic up-counter with synchronous clear, count enable and
//                equality compare against a live limit; wraps naturally.
//  Revision    : 1.0  initial release
// ============================================================================
module timeout_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             match
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign match = (r_count == limit);

endmodule
`default_nettype wire

// File: rtl/byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_packer
//  Description : Pairs consecutive strobed bytes into 16-bit words with a
//                valid/ack handshake, orphan-byte timeout and sticky overrun.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_word_packer
    import byte_word_packer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int TIMEOUT_W = c_default_timeout_w
) (
    input  logic                 Clk_i,
    input  logic                 Reset_i,
    input  logic                 Enable_i,
    input  logic [TIMEOUT_W-1:0] Timeout_i,
    input  logic [7:0]           Data_i,
    input  logic                 Strobe_i,
    input  logic                 Ack_i,
    output logic [15:0]          Word_o,
    output logic                 Valid_o,
    output logic                 Half_o,
    output logic                 Timeout_o,
    output logic                 Overrun_o
);

    pack_state_t          r_state;
    logic [7:0]           r_byte;
    logic [15:0]          r_word;
    logic                 r_valid;
    logic                 r_timeout;
    logic                 r_overrun;

    logic                 w_in_half;
    logic                 w_timeout_en;
    logic [TIMEOUT_W-1:0] w_limit;
    logic                 w_match;
    logic                 w_complete;
    logic                 w_expire;
    logic                 w_timer_clear;
    logic                 w_timer_run;

    assign w_in_half    = (r_state == HALF);
    assign w_timeout_en = (Timeout_i != '0);
    assign w_limit      = Timeout_i - TIMEOUT_W'(1);

    // A strobe on the expiry cycle completes the word, so it masks the timeout.
    assign w_complete = Enable_i && w_in_half && Strobe_i;
    assign w_expire   = Enable_i && w_in_half && !Strobe_i && w_timeout_en && w_match;

    assign w_timer_clear = !Enable_i || !w_in_half || Strobe_i || w_expire;
    assign w_timer_run   = w_in_half && w_timeout_en;

    timeout_counter #(
        .WIDTH (TIMEOUT_W)
    ) u_timeout_counter (
        .clk    (Clk_i),
        .rst    (Reset_i),
        .clear  (w_timer_clear),
        .enable (w_timer_run),
        .limit  (w_limit),
        .match  (w_match)
    );

    always_ff @(posedge Clk_i) begin
        if (Reset_i || !Enable_i) begin
            r_state   <= EMPTY;
            r_byte    <= '0;
            r_word    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_timeout <= w_expire;

            case (r_state)
                EMPTY: begin
                    if (Strobe_i) begin
                        r_byte  <= Data_i;
                        r_state <= HALF;
                    end
                end
                HALF: begin
                    if (Strobe_i) begin
                        r_state <= EMPTY;
                    end else if (w_expire) begin
                        r_byte  <= '0;
                        r_state <= EMPTY;
                    end
                end
            endcase

            // Word register runs independently of the pairing state.
            if (w_complete) begin
                r_word  <= pair_bytes(MSB_FIRST, r_byte, Data_i);
                r_valid <= 1'b1;
                if (r_valid && !Ack_i) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && Ack_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign Word_o    = r_word;
    assign Valid_o   = r_valid;
    assign Half_o    = w_in_half;
    assign Timeout_o = r_timeout;
    assign Overrun_o = r_overrun;

endmodule
`default_nettype wire

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Sits directly downstream of the byte-select mux cell in the reconfigurable WSN fabric.
- Consumes the selected byte stream (e.g. successive I2C/SPI sensor read bytes) and pairs consecutive bytes into 16-bit words for word-width consumers (comparators, word registers).
- Provides a valid/acknowledge handshake, a timeout on an orphaned first byte, and a sticky overrun flag.

Parameters:
- MSB_FIRST, 1, 1: first byte of a pair is Word_o[15:8]; 0: first byte is Word_o[7:0].
- TIMEOUT_W, 8, width of the half-word timeout counter.

Ports:
- Clk_i  in  1  clock; all state changes on its rising edge.
- Reset_i  in  1  synchronous, active-high reset.
- Enable_i  in  1  0 = synchronous clear and idle; 1 = operate.
- Timeout_i  in  TIMEOUT_W  cycles allowed between the first and second byte; 0 disables the timeout.
- Data_i  in  8  byte from the upstream mux.
- Strobe_i  in  1  Data_i is valid this cycle.
- Ack_i  in  1  consumer has taken Word_o.
- Word_o  out  16  assembled word.
- Valid_o  out  1  Word_o holds an unacknowledged word.
- Half_o  out  1  one byte is held, waiting for its partner.
- Timeout_o  out  1  single-cycle pulse: held byte discarded.
- Overrun_o  out  1  sticky: an unacknowledged word was overwritten.

Behaviour:
- Reset_i=1 (has priority over everything): state EMPTY, byte register 0, timer 0, Word_o=0, Valid_o=0, Half_o=0, Timeout_o=0, Overrun_o=0.
- Enable_i=0 (Reset_i=0): same clear as reset. Strobe_i and Ack_i are ignored.
- Two states, EMPTY and HALF; Half_o=1 exactly in HALF. The word register with Valid_o is separate from the state.
- EMPTY + Strobe_i:
  - Capture Data_i into the byte register; timer=0; go to HALF.
- HALF + Strobe_i:
  - Word_o <= {byte, Data_i} if MSB_FIRST=1, else {Data_i, byte}.
  - Valid_o <= 1; go to EMPTY; timer=0.
  - Latency: the word is visible the cycle after the second strobe.
- HALF, no Strobe_i, Timeout_i != 0:
  - Timer increments each cycle.
  - When timer == Timeout_i-1: go to EMPTY, Timeout_o=1 for one cycle, byte discarded, Word_o/Valid_o unchanged.
- A strobe on the expiry cycle wins: the word is completed and no timeout is raised.
- Timeout_i=0: HALF is held indefinitely.
- Handshake:
  - Valid_o=1 and Ack_i=1 with no word completing: Valid_o <= 0; Word_o keeps its value.
  - Ack_i while Valid_o=0: ignored.
  - Word completes while Valid_o=1 and Ack_i=1: new word loaded, Valid_o stays 1, no overrun.
  - Word completes while Valid_o=1 and Ack_i=0: Word_o overwritten, Valid_o stays 1, Overrun_o <= 1. Overrun_o stays set until reset or Enable_i=0.
- Timeout_i changed mid-HALF: compared live; if timer has already passed the new Timeout_i-1, counting continues and wraps modulo 2^TIMEOUT_W until equality.
- Back-to-back strobes every cycle: one word per two cycles, with no bubble needed.

Decomposition:
- Shared package: state encoding (EMPTY=1'b0, HALF=1'b1) and the default TIMEOUT_W constant.
- No sub-module is needed.
- The timer may optionally be split out as a generic up-counter with synchronous clear, compare and enable, named timeout_counter.

Test Plan:
- Reset/enable clear: preload Valid_o=1, Word_o=0x1234, Overrun_o=1 -> assert Reset_i one cycle -> all outputs 0 next cycle. Repeat with Enable_i=0 -> same result.
- Pairing, MSB_FIRST=1:
  - Strobe 0xAB, then 0xCD on consecutive cycles -> Word_o=0xABCD and Valid_o=1 one cycle after 0xCD.
  - Half_o=1 only between the two strobes.
  - With MSB_FIRST=0 the same stimulus gives 0xCDAB.
- Timeout, Timeout_i=4: strobe 0x11, then idle -> Timeout_o pulses exactly one cycle, 4 cycles after the strobe, and Half_o drops. A following 0x22,0x33 pair -> Word_o=0x2233, not 0x1122.
- Strobe on expiry, Timeout_i=4: second strobe 0x55 lands on the expiry cycle -> no Timeout_o, word completes. With Timeout_i=0 and a 300-cycle gap -> the word still completes.
- Overrun:
  - Complete 0x0102 and hold Ack_i=0, then complete 0x0304 -> Word_o=0x0304, Valid_o=1, Overrun_o=1.
  - Repeat with Ack_i=1 on the completion cycle -> Overrun_o stays 0.
- Streaming: strobe every cycle with bytes 0x00..0x07 and Ack_i tied high -> words 0x0001, 0x0203, 0x0405, 0x0607 on alternate cycles, no overrun, no timeout.
